// File: rtl/memory_stage.sv
// MEM stage of the 24-bit pipeline: registers execute-stage results, performs a
// RAM or memory-mapped I/O access, and presents read data plus write-back control.
module memory_stage #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [23:0] IO_BASE   = 24'hFFFFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  opType,
  input  logic [3:0]  opCode,
  input  logic [23:0] address1,
  input  logic [23:0] address2,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  input  logic [3:0]  Rc,
  input  logic [23:0] writeData,
  input  logic [3:0]  switches,
  input  logic [35:0] gpio1,
  output logic [35:0] gpio2,
  output logic [23:0] q,
  output logic [35:0] bufferOut
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [23:0] IO_SWITCHES = IO_BASE;
  localparam logic [23:0] IO_GPIO1_LO = IO_BASE + 24'd1;
  localparam logic [23:0] IO_GPIO2_LO = IO_BASE + 24'd2;
  localparam logic [23:0] IO_GPIO2_HI = IO_BASE + 24'd3;
  localparam logic [23:0] IO_GPIO1_HI = IO_BASE + 24'd4;

  logic [23:0] ram [MEM_DEPTH];

  logic [1:0]  in_op_type;
  logic [3:0]  in_op_code;
  logic [23:0] in_address1;
  logic        in_mem_write;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [3:0]  in_rc;
  logic [23:0] in_write_data;

  logic        addr1_in_ram;
  logic        addr2_in_ram;
  logic        ram_we;
  logic        store_active;
  logic [23:0] read_data;

  assign addr1_in_ram = 32'(in_address1) < MEM_DEPTH;
  assign addr2_in_ram = 32'(address2) < MEM_DEPTH;
  assign store_active = !rst && en && in_mem_write;
  assign ram_we       = store_active && addr1_in_ram;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_op_type    <= '0;
      in_op_code    <= '0;
      in_address1   <= '0;
      in_mem_write  <= 1'b0;
      in_mem_to_reg <= 1'b0;
      in_reg_write  <= 1'b0;
      in_rc         <= '0;
      in_write_data <= '0;
    end else if (en) begin
      in_op_type    <= opType;
      in_op_code    <= opCode;
      in_address1   <= address1;
      in_mem_write  <= memWrite;
      in_mem_to_reg <= memToReg;
      in_reg_write  <= regWrite;
      in_rc         <= Rc;
      in_write_data <= writeData;
    end
  end

  // RAM contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[in_address1[AW-1:0]] <= in_write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio2 <= '0;
    end else if (store_active) begin
      if (in_address1 == IO_GPIO2_LO)
        gpio2[23:0] <= in_write_data;
      else if (in_address1 == IO_GPIO2_HI)
        gpio2[35:24] <= in_write_data[11:0];
    end
  end

  // A store returns its own data so write-back sees a consistent value.
  always_comb begin
    read_data = '0;
    if (in_mem_write) begin
      read_data = in_write_data;
    end else if (addr1_in_ram) begin
      read_data = ram[in_address1[AW-1:0]];
    end else begin
      case (in_address1)
        IO_SWITCHES: read_data = {20'b0, switches};
        IO_GPIO1_LO: read_data = gpio1[23:0];
        IO_GPIO1_HI: read_data = {12'b0, gpio1[35:24]};
        IO_GPIO2_LO: read_data = gpio2[23:0];
        IO_GPIO2_HI: read_data = {12'b0, gpio2[35:24]};
        default:     read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bufferOut <= '0;
    else if (en)
      bufferOut <= {in_op_type, in_op_code, in_mem_to_reg, in_reg_write, in_rc, read_data};
  end

  // Second port bypasses a same-edge write to the same word (write-first).
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!addr2_in_ram)
      q <= '0;
    else if (ram_we && (in_address1 == address2))
      q <= in_write_data;
    else
      q <= ram[address2[AW-1:0]];
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// traffic compared against a transaction-level model of the stage.
module tb_memory_stage;

  localparam int unsigned DEPTH = 1024;
  localparam logic [23:0] IOB   = 24'hFFFFF0;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  opType;
  logic [3:0]  opCode;
  logic [23:0] address1, address2;
  logic        memWrite, memToReg, regWrite;
  logic [3:0]  Rc;
  logic [23:0] writeData;
  logic [3:0]  switches;
  logic [35:0] gpio1;
  logic [35:0] gpio2;
  logic [23:0] q;
  logic [35:0] bufferOut;

  memory_stage #(.MEM_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
    .clk(clk), .rst(rst), .en(en), .opType(opType), .opCode(opCode),
    .address1(address1), .address2(address2), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .Rc(Rc), .writeData(writeData),
    .switches(switches), .gpio1(gpio1), .gpio2(gpio2), .q(q), .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op_type;
    logic [3:0]  op_code;
    logic [23:0] addr;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [3:0]  rc;
    logic [23:0] wdata;
  } txn_t;

  // Model state: memory image, I/O output register, and the expected outputs.
  logic [23:0] m_ram [DEPTH];
  logic [35:0] m_gpio2 = '0;
  logic [35:0] m_bo = '0;
  logic [23:0] m_q = '0;
  txn_t        m_pend = '0;

  int checks = 0;
  int passed = 0;

  function automatic txn_t mk(input logic [1:0] ot, input logic [3:0] oc, input logic [23:0] a,
                              input logic mw, input logic mtr, input logic rw,
                              input logic [3:0] rc, input logic [23:0] wd);
    txn_t t;
    t.op_type = ot; t.op_code = oc; t.addr = a; t.mem_write = mw;
    t.mem_to_reg = mtr; t.reg_write = rw; t.rc = rc; t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t nop();
    return mk(2'd0, 4'd0, 24'h100000, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0);
  endfunction

  function automatic logic [23:0] model_read(input txn_t p);
    if (p.mem_write) return p.wdata;
    if (32'(p.addr) < DEPTH) return m_ram[p.addr[9:0]];
    if (p.addr == IOB) return {20'b0, switches};
    if (p.addr == IOB + 24'd1) return gpio1[23:0];
    if (p.addr == IOB + 24'd2) return m_gpio2[23:0];
    if (p.addr == IOB + 24'd3) return {12'b0, m_gpio2[35:24]};
    if (p.addr == IOB + 24'd4) return {12'b0, gpio1[35:24]};
    return 24'd0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1ns after.
  task automatic cycle(input logic r, input logic e, input txn_t t, input logic [23:0] a2);
    logic [23:0] rd;
    @(negedge clk);
    rst = r; en = e; opType = t.op_type; opCode = t.op_code; address1 = t.addr;
    memWrite = t.mem_write; memToReg = t.mem_to_reg; regWrite = t.reg_write;
    Rc = t.rc; writeData = t.wdata; address2 = a2;
    if (r) begin
      m_pend = '0; m_bo = '0; m_q = '0; m_gpio2 = '0;
    end else begin
      rd = model_read(m_pend);
      if (e && m_pend.mem_write) begin
        if (32'(m_pend.addr) < DEPTH) m_ram[m_pend.addr[9:0]] = m_pend.wdata;
        else if (m_pend.addr == IOB + 24'd2) m_gpio2[23:0] = m_pend.wdata;
        else if (m_pend.addr == IOB + 24'd3) m_gpio2[35:24] = m_pend.wdata[11:0];
      end
      m_q = (32'(a2) < DEPTH) ? m_ram[a2[9:0]] : 24'd0;
      if (e) begin
        m_bo = {m_pend.op_type, m_pend.op_code, m_pend.mem_to_reg, m_pend.reg_write, m_pend.rc, rd};
        m_pend = t;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, nop(), 24'd0);
    cycle(1'b1, 1'b1, nop(), 24'd0);
    checks++; if (bufferOut !== 36'd0) $display("FAIL reset_bo: got %h exp 0", bufferOut); else passed++;
    checks++; if (q !== 24'd0) $display("FAIL reset_q: got %h exp 0", q); else passed++;
    checks++; if (gpio2 !== 36'd0) $display("FAIL reset_gpio2: got %h exp 0", gpio2); else passed++;
  endtask

  task automatic preload();
    for (int i = 0; i < int'(DEPTH); i++)
      cycle(1'b0, 1'b1, mk(2'd0, 4'd0, 24'(i), 1'b1, 1'b0, 1'b0, 4'd0, 24'($urandom())), 24'd0);
    cycle(1'b0, 1'b1, nop(), 24'd0);
  endtask

  task automatic test_store_load();
    cycle(1'b0, 1'b1, mk(2'd2, 4'd9, 24'd500, 1'b1, 1'b0, 1'b0, 4'd12, 24'd35), 24'd0);
    cycle(1'b0, 1'b1, mk(2'd2, 4'd9, 24'd500, 1'b0, 1'b1, 1'b1, 4'd12, 24'd0), 24'd500);
    checks++;
    if (bufferOut !== {2'b10, 4'b1001, 1'b0, 1'b0, 4'd12, 24'd35})
      $display("FAIL store_bypass: got %h exp %h", bufferOut, {2'b10, 4'b1001, 1'b0, 1'b0, 4'd12, 24'd35});
    else passed++;
    checks++; if (q !== 24'd35) $display("FAIL q_write_first: got %0d exp 35", q); else passed++;
    cycle(1'b0, 1'b1, nop(), 24'd500);
    checks++; if (bufferOut[23:0] !== 24'd35) $display("FAIL load_back: got %0d exp 35", bufferOut[23:0]); else passed++;
    checks++; if (bufferOut[29:28] !== 2'b11) $display("FAIL load_flags: got %b exp 11", bufferOut[29:28]); else passed++;
    checks++; if (q !== 24'd35) $display("FAIL q_read: got %0d exp 35", q); else passed++;
  endtask

  task automatic test_io();
    logic [23:0] exp_bo [6];
    exp_bo[0] = 24'd13; exp_bo[1] = 24'd23; exp_bo[2] = 24'hABCDEF;
    exp_bo[3] = 24'h123456; exp_bo[4] = 24'hABCDEF; exp_bo[5] = 24'h000456;
    switches = 4'b1101;
    gpio1 = {12'hABC, 24'd23};
    cycle(1'b0, 1'b1, mk(2'd1, 4'd3, IOB, 1'b0, 1'b1, 1'b1, 4'd1, 24'd0), 24'd0);
    cycle(1'b0, 1'b1, mk(2'd1, 4'd3, IOB + 24'd1, 1'b0, 1'b1, 1'b1, 4'd2, 24'd0), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[0]) $display("FAIL io_switches: got %h exp %h", bufferOut[23:0], exp_bo[0]); else passed++;
    cycle(1'b0, 1'b1, mk(2'd1, 4'd4, IOB + 24'd2, 1'b1, 1'b0, 1'b0, 4'd0, 24'hABCDEF), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[1]) $display("FAIL io_gpio1_lo: got %h exp %h", bufferOut[23:0], exp_bo[1]); else passed++;
    cycle(1'b0, 1'b1, mk(2'd1, 4'd4, IOB + 24'd3, 1'b1, 1'b0, 1'b0, 4'd0, 24'h123456), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[2]) $display("FAIL io_store_bypass: got %h exp %h", bufferOut[23:0], exp_bo[2]); else passed++;
    checks++; if (gpio2[23:0] !== 24'hABCDEF) $display("FAIL gpio2_lo: got %h exp abcdef", gpio2[23:0]); else passed++;
    cycle(1'b0, 1'b1, mk(2'd1, 4'd3, IOB + 24'd2, 1'b0, 1'b1, 1'b1, 4'd3, 24'd0), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[3]) $display("FAIL io_store_hi_bypass: got %h exp %h", bufferOut[23:0], exp_bo[3]); else passed++;
    checks++; if (gpio2 !== {12'h456, 24'hABCDEF}) $display("FAIL gpio2_full: got %h exp 456abcdef", gpio2); else passed++;
    cycle(1'b0, 1'b1, mk(2'd1, 4'd3, IOB + 24'd3, 1'b0, 1'b1, 1'b1, 4'd4, 24'd0), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[4]) $display("FAIL io_gpio2_lo_read: got %h exp %h", bufferOut[23:0], exp_bo[4]); else passed++;
    cycle(1'b0, 1'b1, mk(2'd1, 4'd3, IOB + 24'd4, 1'b0, 1'b1, 1'b1, 4'd5, 24'd0), 24'd0);
    checks++; if (bufferOut[23:0] !== exp_bo[5]) $display("FAIL io_gpio2_hi_read: got %h exp %h", bufferOut[23:0], exp_bo[5]); else passed++;
    cycle(1'b0, 1'b1, nop(), 24'd0);
    checks++; if (bufferOut[23:0] !== 24'h000ABC) $display("FAIL io_gpio1_hi: got %h exp 000abc", bufferOut[23:0]); else passed++;
  endtask

  task automatic test_enable_hold();
    logic [35:0] saved_bo;
    logic [23:0] saved7;
    cycle(1'b0, 1'b1, nop(), 24'd0);
    saved_bo = m_bo;
    saved7 = m_ram[7];
    cycle(1'b0, 1'b0, mk(2'd0, 4'd1, 24'd7, 1'b1, 1'b0, 1'b0, 4'd0, 24'd99), 24'd7);
    cycle(1'b0, 1'b0, mk(2'd0, 4'd1, 24'd7, 1'b1, 1'b0, 1'b0, 4'd0, 24'd99), 24'd9);
    checks++; if (bufferOut !== saved_bo) $display("FAIL en_hold_bo: got %h exp %h", bufferOut, saved_bo); else passed++;
    checks++; if (q !== m_q) $display("FAIL en_low_q: got %h exp %h", q, m_q); else passed++;
    cycle(1'b0, 1'b1, mk(2'd0, 4'd1, 24'd7, 1'b0, 1'b1, 1'b1, 4'd0, 24'd0), 24'd7);
    cycle(1'b0, 1'b1, nop(), 24'd7);
    checks++; if (bufferOut[23:0] !== saved7) $display("FAIL en_no_write: got %h exp %h", bufferOut[23:0], saved7); else passed++;
    checks++; if (q !== saved7) $display("FAIL en_no_write_q: got %h exp %h", q, saved7); else passed++;
  endtask

  task automatic test_out_of_range();
    cycle(1'b0, 1'b1, mk(2'd0, 4'd2, 24'd5000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h5A5A5A), 24'd0);
    cycle(1'b0, 1'b1, mk(2'd0, 4'd2, 24'd5000, 1'b0, 1'b1, 1'b1, 4'd6, 24'd0), 24'd0);
    checks++; if (bufferOut[23:0] !== 24'h5A5A5A) $display("FAIL oor_store_bypass: got %h exp 5a5a5a", bufferOut[23:0]); else passed++;
    cycle(1'b0, 1'b1, mk(2'd0, 4'd2, 24'd904, 1'b0, 1'b1, 1'b1, 4'd6, 24'd0), 24'd904);
    checks++; if (bufferOut[23:0] !== 24'd0) $display("FAIL oor_load: got %h exp 0", bufferOut[23:0]); else passed++;
    cycle(1'b0, 1'b1, nop(), 24'd5000);
    checks++; if (bufferOut[23:0] !== m_ram[904]) $display("FAIL oor_no_alias: got %h exp %h", bufferOut[23:0], m_ram[904]); else passed++;
    checks++; if (q !== 24'd0) $display("FAIL oor_q: got %h exp 0", q); else passed++;
  endtask

  task automatic test_reset_midop();
    cycle(1'b0, 1'b1, mk(2'd3, 4'd5, 24'd500, 1'b1, 1'b0, 1'b0, 4'd0, 24'd77), 24'd500);
    cycle(1'b1, 1'b1, mk(2'd3, 4'd5, 24'd500, 1'b1, 1'b0, 1'b0, 4'd0, 24'd88), 24'd500);
    checks++; if (bufferOut !== 36'd0) $display("FAIL midop_reset_bo: got %h exp 0", bufferOut); else passed++;
    checks++; if (q !== 24'd0) $display("FAIL midop_reset_q: got %h exp 0", q); else passed++;
    checks++; if (gpio2 !== 36'd0) $display("FAIL midop_reset_gpio2: got %h exp 0", gpio2); else passed++;
    cycle(1'b0, 1'b1, mk(2'd0, 4'd0, 24'd500, 1'b0, 1'b1, 1'b1, 4'd0, 24'd0), 24'd500);
    checks++; if (q !== 24'd35) $display("FAIL midop_ram_kept_q: got %0d exp 35", q); else passed++;
    cycle(1'b0, 1'b1, nop(), 24'd0);
    checks++; if (bufferOut[23:0] !== 24'd35) $display("FAIL midop_ram_kept: got %0d exp 35", bufferOut[23:0]); else passed++;
  endtask

  task automatic test_random();
    txn_t t;
    logic [23:0] a;
    logic [23:0] a2;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = 24'($urandom_range(0, 15));
        1: a = 24'($urandom_range(0, DEPTH - 1));
        2: a = IOB + 24'($urandom_range(0, 5));
        default: a = 24'($urandom());
      endcase
      a2 = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 15)) : 24'($urandom_range(0, DEPTH + 7));
      t = mk(2'($urandom()), 4'($urandom()), a, 1'($urandom()), 1'($urandom()),
             1'($urandom()), 4'($urandom()), 24'($urandom()));
      switches = 4'($urandom());
      gpio1 = {4'($urandom()), 32'($urandom())};
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), t, a2);
      checks++; if (bufferOut !== m_bo) $display("FAIL rand_bo[%0d]: got %h exp %h", n, bufferOut, m_bo); else passed++;
      checks++; if (q !== m_q) $display("FAIL rand_q[%0d]: got %h exp %h", n, q, m_q); else passed++;
      checks++; if (gpio2 !== m_gpio2) $display("FAIL rand_gpio2[%0d]: got %h exp %h", n, gpio2, m_gpio2); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opType = '0; opCode = '0; address1 = '0; address2 = '0;
    memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0; Rc = '0; writeData = '0;
    switches = '0; gpio1 = '0;
    test_reset();
    preload();
    test_store_load();
    test_io();
    test_enable_hold();
    test_out_of_range();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 24-bit pipelined processor; sits between the execute-stage pipeline register and write-back.
- Registers incoming control and data, then performs a data-memory or memory-mapped I/O access.
- Presents the read data plus the forwarded write-back control in a 36-bit output pipeline buffer.
- Provides a second read port (address2 -> q) for display/debug readout.

Parameters:
- MEM_DEPTH, 1024, number of 24-bit RAM words (addresses 0..MEM_DEPTH-1).
- IO_BASE, 24'hFFFFF0, base address of the memory-mapped I/O window.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  stage enable; 0 = hold all pipeline state and suppress writes.
- opType  input  2  instruction type, forwarded.
- opCode  input  4  opcode, forwarded.
- address1  input  24  data access address (load/store).
- address2  input  24  second read-port address.
- memWrite  input  1  store enable.
- memToReg  input  1  write-back select flag, forwarded.
- regWrite  input  1  register-write flag, forwarded.
- Rc  input  4  destination register, forwarded.
- writeData  input  24  store data.
- switches  input  4  board switches, readable via I/O.
- gpio1  input  36  external input port, readable via I/O.
- gpio2  output  36  external output port, written via I/O.
- q  output  24  second-port read data.
- bufferOut  output  36  output pipeline buffer.

Behaviour:
- Input buffer, rising edge, when en=1: captures opType, opCode, address1, memWrite, memToReg, regWrite, Rc, writeData. Holds when en=0.
- Write path uses the registered inputs (in_*). In the cycle after capture, on the rising edge with en=1 and in_memWrite=1:
  - in_address1 < MEM_DEPTH: RAM[in_address1] <= in_writeData.
  - in_address1 = IO_BASE+2: gpio2[23:0] <= in_writeData.
  - in_address1 = IO_BASE+3: gpio2[35:24] <= in_writeData[11:0].
  - Any other address: write ignored.
- Read data (combinational from in_address1, write-first):
  - If in_memWrite=1, readData = in_writeData (bypass, so a store returns its own data).
  - Else, in_address1 < MEM_DEPTH: RAM word.
  - Else, IO_BASE: {20'b0, switches}.
  - Else, IO_BASE+1: gpio1[23:0].
  - Else, IO_BASE+4: {12'b0, gpio1[35:24]}.
  - Else, IO_BASE+2/+3: current gpio2 field, zero-extended.
  - Else: 0.
- Output buffer, rising edge, when en=1: bufferOut <= {in_opType, in_opCode, in_memToReg, in_regWrite, in_Rc, readData}.
  - Bit layout: [35:34] opType, [33:30] opCode, [29] memToReg, [28] regWrite, [27:24] Rc, [23:0] readData.
  - [23:0] always carries readData, independent of memToReg; write-back does the final mux.
- Latency: inputs present before rising edge N -> bufferOut valid after edge N+1 (2 cycles).
- q: registered RAM read of address2 (<MEM_DEPTH, else 0) every rising edge, independent of en.
  - Same-edge write to that address returns new data.
- Reset (rst=1 at rising edge, overrides en):
  - Input buffer, bufferOut, q and gpio2 cleared to 0.
  - No RAM write occurs on that edge.
  - RAM contents are not cleared.
  - Reset mid-operation discards in-flight state.
- en=0: no RAM/gpio2 writes; both buffers hold; q still updates.
- Address compares use the full 24 bits; no wrap-around. Addresses outside RAM and the I/O window read 0 and ignore writes.

Test Plan:
- Store/bypass: rst 1 cycle; then en=1, memWrite=1, address1=500, writeData=35, opType=2, opCode=9, memToReg=0, regWrite=0, Rc=12. After 2 edges: bufferOut[35:28]=8'b10_1001_0_0, [27:24]=12, [23:0]=35.
- Load-back: following cycle memWrite=0, address1=500, memToReg=1, regWrite=1 -> bufferOut[23:0]=35, [29:28]=2'b11. Also address2=500 -> q=35 one edge later.
- I/O: switches=4'b1101, address1=IO_BASE -> bufferOut[23:0]=13.
  - gpio1=23, address1=IO_BASE+1 -> 23.
  - Store 24'hABCDEF to IO_BASE+2 -> gpio2[23:0]=24'hABCDEF.
- Enable hold: en=0 with memWrite=1, address1=7, writeData=99 -> bufferOut unchanged; later load from 7 returns prior RAM value.
- Reset: assert rst while en=1, memWrite=1 -> after edge bufferOut=0, q=0, gpio2=0; previously stored RAM[500] still reads 35.
- Out-of-range: store to address 5000 (MEM_DEPTH=1024) then load -> readData 0, no RAM word modified.
